// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU.
// Op codes, FSM states, flag bundle and the seven-segment table.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLT = 4'd6,
    OP_EQ  = 4'd7,
    OP_MUL = 4'd8,
    OP_SLL = 4'd9,
    OP_SRL = 4'd10,
    OP_SRA = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic compare_out;
    logic err;
  } flags_t;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0-F
  localparam logic [6:0] SEG7_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG7_BLANK_N = 7'h7F;

endpackage

// File: rtl/hex_seg7.sv
// Hex nibble to seven-segment decoder.
// Polarity selectable so boards with either drive sense can reuse it.
module hex_seg7
  import alu_seq_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_ACTIVE_LOW ? SEG7_N[hex] : ~SEG7_N[hex];

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with iterative multiply and registered hex display.
// One op in flight; result and flags hold until the consumer takes them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             compare_out,
  output logic             err,
  output logic [6:0]       seg0,
  output logic [6:0]       seg1
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [6:0] SEG_BLANK =
    SEG_ACTIVE_LOW ? SEG7_BLANK_N : ~SEG7_BLANK_N;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nx;
  logic [WIDTH-1:0]   mplr_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0] res_q, alu_res, mul_res, new_res;
  flags_t           flg_q, alu_flg, mul_flg, new_flg;
  logic [6:0]       seg0_q, seg1_q, seg0_nx, seg1_nx;
  logic [3:0]       nib1;

  logic start_mul, load_res, sel_mul;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic             slt, eq;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];
  assign slt   = $signed(a) < $signed(b);
  assign eq    = a == b;

  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    case (op)
      OP_ADD: begin
        alu_res          = sum[WIDTH-1:0];
        alu_flg.carry    = sum[WIDTH];
        alu_flg.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                           (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res          = diff[WIDTH-1:0];
        alu_flg.carry    = diff[WIDTH];
        alu_flg.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                           (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: alu_res = ~a;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: begin
        alu_res[0]          = slt;
        alu_flg.compare_out = slt;
      end
      OP_EQ: begin
        alu_res[0]          = eq;
        alu_flg.compare_out = eq;
      end
      OP_MUL: alu_res = '0;
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $signed(a) >>> shamt;
      default: alu_flg.err = 1'b1;
    endcase
    alu_flg.zero = alu_res == '0;
  end

  // One multiplier bit retired per BUSY cycle
  assign acc_nx  = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign mul_res = acc_nx[WIDTH-1:0];

  always_comb begin
    mul_flg       = '0;
    mul_flg.carry = |acc_nx[2*WIDTH-1:WIDTH];
    mul_flg.zero  = mul_res == '0;
  end

  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    load_res  = 1'b0;
    sel_mul   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d   = S_BUSY;
            start_mul = 1'b1;
          end else begin
            state_d  = S_DONE;
            load_res = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          load_res = 1'b1;
          sel_mul  = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign new_res = sel_mul ? mul_res : alu_res;
  assign new_flg = sel_mul ? mul_flg : alu_flg;

  generate
    if (WIDTH >= 8) begin : g_nib1
      assign nib1 = new_res[7:4];
    end else begin : g_nib1_zero
      assign nib1 = 4'h0;
    end
  endgenerate

  hex_seg7 #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg0 (
    .hex(new_res[3:0]),
    .seg(seg0_nx)
  );

  hex_seg7 #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg1 (
    .hex(nib1),
    .seg(seg1_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      seg0_q  <= SEG_BLANK;
      seg1_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      if (start_mul) begin
        mcand_q <= {{WIDTH{1'b0}}, a};
        mplr_q  <= b;
        acc_q   <= '0;
        cnt_q   <= CW'(WIDTH);
      end else if (state_q == S_BUSY) begin
        acc_q   <= acc_nx;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q - CW'(1);
      end
      if (load_res) begin
        res_q  <= new_res;
        flg_q  <= new_flg;
        seg0_q <= seg0_nx;
        seg1_q <= seg1_nx;
      end
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign out_valid   = state_q == S_DONE;
  assign result      = res_q;
  assign zero        = flg_q.zero;
  assign carry       = flg_q.carry;
  assign overflow    = flg_q.overflow;
  assign compare_out = flg_q.compare_out;
  assign err         = flg_q.err;
  assign seg0        = seg0_q;
  assign seg1        = seg1_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=8, active-low segments.
// Expected values come from an integer reference model queued at acceptance.
module tb_alu_seq;

  typedef struct {
    logic [7:0] r;
    logic       z, c, v, cmp, e;
    logic [6:0] s0, s1;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       zero, carry, overflow, compare_out, err;
  logic [6:0] seg0, seg1;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(8),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .carry(carry),
    .overflow(overflow),
    .compare_out(compare_out),
    .err(err),
    .seg0(seg0),
    .seg1(seg1)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [7:0] x,
                                 input logic [7:0] y);
    exp_t e;
    int ua, ub, sa, sb, t;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    e = '{r: 8'h00, z: 1'b0, c: 1'b0, v: 1'b0, cmp: 1'b0, e: 1'b0,
          s0: 7'h00, s1: 7'h00, lat: 1};
    case (o)
      4'd0: begin
        t = ua + ub;
        e.r = t[7:0];
        e.c = t > 255;
        e.v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'd1: begin
        t = ua - ub;
        e.r = t[7:0];
        e.c = ua < ub;
        e.v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'd2: e.r = ~x;
      4'd3: e.r = x & y;
      4'd4: e.r = x | y;
      4'd5: e.r = x ^ y;
      4'd6: begin
        e.cmp = sa < sb;
        e.r = {7'b0, e.cmp};
      end
      4'd7: begin
        e.cmp = ua == ub;
        e.r = {7'b0, e.cmp};
      end
      4'd8: begin
        t = ua * ub;
        e.r = t[7:0];
        e.c = t > 255;
        e.lat = 9;
      end
      4'd9:  begin t = ua << y[2:0];  e.r = t[7:0]; end
      4'd10: begin t = ua >> y[2:0];  e.r = t[7:0]; end
      4'd11: begin t = sa >>> y[2:0]; e.r = t[7:0]; end
      default: e.e = 1'b1;
    endcase
    e.z  = e.r == 8'h00;
    e.s0 = seg7(e.r[3:0]);
    e.s1 = seg7(e.r[7:4]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [7:0] x,
                      input logic [7:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int n = 0; n < 40 && !in_ready; n++) tick();
    if (!in_ready) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(model(o, x, y));
      tick();
      in_valid = 1'b0;
    end
  endtask

  // hold > 0 keeps out_ready low and offers a new ADD meanwhile
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      chk({tag, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
      tick();
      n++;
    end
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_result"}, {24'b0, result}, {24'b0, e.r});
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, e.z});
    chk({tag, "_carry"}, {31'b0, carry}, {31'b0, e.c});
    chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, e.v});
    chk({tag, "_compare"}, {31'b0, compare_out}, {31'b0, e.cmp});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e.e});
    chk({tag, "_seg0"}, {25'b0, seg0}, {25'b0, e.s0});
    chk({tag, "_seg1"}, {25'b0, seg1}, {25'b0, e.s1});
    if (hold > 0) begin
      in_valid = 1'b1;
      op = 4'd0;
      a = 8'h11;
      b = 8'h22;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_hold_result"}, {24'b0, result}, {24'b0, e.r});
        chk({tag, "_hold_err"}, {31'b0, err}, {31'b0, e.e});
        chk({tag, "_hold_seg0"}, {25'b0, seg0}, {25'b0, e.s0});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_post_seg0"}, {25'b0, seg0}, {25'b0, e.s0});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 4'd0;
    a = 8'h00;
    b = 8'h00;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_flags", {27'b0, zero, carry, overflow, compare_out, err}, 32'd0);
    chk("rst_seg0", {25'b0, seg0}, 32'h7F);
    chk("rst_seg1", {25'b0, seg1}, 32'h7F);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", {31'b0, in_ready}, 32'd1);

    send(4'd0, 8'h7F, 8'h01);  collect("add_ovf", 0);
    send(4'd1, 8'h05, 8'h05);  collect("sub_zero", 0);
    send(4'd1, 8'h03, 8'h05);  collect("sub_borrow", 0);
    send(4'd0, 8'hFF, 8'h02);  collect("add_carry", 0);
    send(4'd1, 8'h80, 8'h01);  collect("sub_ovf", 0);
    send(4'd8, 8'h10, 8'h11);  collect("mul_hi", 0);
    send(4'd8, 8'h03, 8'h05);  collect("mul_lo", 0);
    send(4'd8, 8'hFF, 8'hFF);  collect("mul_max", 0);
    send(4'd6, 8'hFF, 8'h01);  collect("slt_true", 0);
    send(4'd6, 8'h01, 8'hFF);  collect("slt_false", 0);
    send(4'd7, 8'h2A, 8'h2A);  collect("eq_true", 0);
    send(4'd11, 8'h80, 8'h03); collect("sra", 0);
    send(4'd10, 8'h80, 8'hFB); collect("srl_mask", 0);
    send(4'd9, 8'h81, 8'hF9);  collect("sll_mask", 0);
    send(4'd2, 8'h5A, 8'h00);  collect("not", 0);
    send(4'd5, 8'hF0, 8'h3C);  collect("xor", 0);
    send(4'd3, 8'hF0, 8'h3C);  collect("and", 0);
    send(4'd4, 8'hA0, 8'h0B);  collect("or", 0);

    send(4'hC, 8'h12, 8'h34);  collect("illegal_hold", 5);
    send(4'd0, 8'h11, 8'h22);  collect("add_after_hold", 0);
    send(4'hF, 8'hFF, 8'hFF);  collect("illegal_f", 0);

    send(4'd8, 8'h03, 8'h07);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", {24'b0, result}, 32'd0);
    chk("abort_seg0", {25'b0, seg0}, 32'h7F);
    chk("abort_seg1", {25'b0, seg1}, 32'h7F);
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("abort_rel_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_no_result", {31'b0, out_valid}, 32'd0);
    send(4'd0, 8'h21, 8'h43);  collect("add_after_abort", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
